// File: rtl/maf_issue_ctrl.sv
// maf_issue_ctrl: issue controller for the shared multiply-add-fused pipeline.
//
// Arbitrates two requesters round-robin, produces the per-op lane-mode code (cont) for T1,
// enforces idle cycles between ops with different cont codes, and tracks in-flight ops through
// a fixed-latency shift. Results land in a small buffer whose space is reserved by credits at
// issue, so the pipe never has to stall.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake; ready is combinational and one-hot or zero
//   req_mode, req_tag     {req1,req0} 3-bit cont codes and tags
//   flush                 synchronous kill of everything in flight or buffered
//   iss_valid/cont/src/tag op issued into the pipe this cycle (cont 011 = null op)
//   rb_wr_ptr, rb_rd_ptr  result-buffer write index (pipe output) and head index
//   res_valid/src/tag/err head result; res_ready pops it
//   busy                  any op in the pipe or the result buffer
module maf_issue_ctrl #(
  parameter int unsigned PIPE_DEPTH = 8,
  parameter int unsigned RES_DEPTH  = 4,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned MODE_GAP   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [5:0]                   req_mode,
  input  logic [2*TAG_W-1:0]           req_tag,
  input  logic                         flush,
  output logic                         iss_valid,
  output logic [2:0]                   iss_cont,
  output logic                         iss_src,
  output logic [TAG_W-1:0]             iss_tag,
  output logic [$clog2(RES_DEPTH)-1:0] rb_wr_ptr,
  output logic [$clog2(RES_DEPTH)-1:0] rb_rd_ptr,
  output logic                         res_valid,
  output logic                         res_src,
  output logic [TAG_W-1:0]             res_tag,
  output logic                         res_err,
  input  logic                         res_ready,
  output logic                         busy
);

  localparam int unsigned PtrW = $clog2(RES_DEPTH);
  localparam int unsigned CntW = $clog2(RES_DEPTH + 1);
  localparam int unsigned AgeW = $clog2(MODE_GAP + 1);

  localparam logic [2:0]      ContNull    = 3'b011;
  localparam logic [CntW-1:0] CreditsFull = CntW'(RES_DEPTH);
  // Age saturates at MODE_GAP: "long enough ago" that a cont change needs no gap.
  localparam logic [AgeW-1:0] AgeSat      = AgeW'(MODE_GAP);
  localparam logic [AgeW-1:0] GapInit     = AgeW'(MODE_GAP - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  // Control state
  state_e          state_q, state_d;
  logic [AgeW-1:0] gap_cnt_q, gap_cnt_d;
  logic [AgeW-1:0] age_q, age_d;           // cycles since last non-null issue
  logic [2:0]      last_cont_q, last_cont_d;
  logic            rr_q, rr_d;             // requester preferred when both are valid
  logic [CntW-1:0] credits_q, credits_d;

  // Pipe tracking shift
  logic [PIPE_DEPTH-1:0] pipe_vld_q;
  logic [PIPE_DEPTH-1:0] pipe_src_q;
  logic [PIPE_DEPTH-1:0] pipe_err_q;
  logic [TAG_W-1:0]      pipe_tag_q [PIPE_DEPTH];

  // Result buffer
  logic             rb_src_q [RES_DEPTH];
  logic             rb_err_q [RES_DEPTH];
  logic [TAG_W-1:0] rb_tag_q [RES_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;

  // Arbitration and issue decision
  logic             win;
  logic [2:0]       win_mode;
  logic [TAG_W-1:0] win_tag;
  logic             win_legal;
  logic [2:0]       win_cont;
  logic             can_try;
  logic             need_gap;
  logic             grant;
  logic             rb_wr;
  logic             pop;

  always_comb begin
    win = rr_q;
    if (req_valid == 2'b01) begin
      win = 1'b0;
    end else if (req_valid == 2'b10) begin
      win = 1'b1;
    end
    win_mode = win ? req_mode[5:3] : req_mode[2:0];
    win_tag  = win ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
  end

  // Legal codes are 000, 001, 010; everything else is issued as a null op with err set.
  assign win_legal = ~win_mode[2] & (win_mode != ContNull);
  assign win_cont  = win_legal ? win_mode : ContNull;

  assign can_try  = ~flush & (state_q != StGap) & (credits_q != '0) & (|req_valid);
  // Null ops never force a gap.
  assign need_gap = win_legal & (win_cont != last_cont_q) & (age_q < AgeSat);
  assign grant    = can_try & ~need_gap;

  assign iss_valid = grant;
  assign iss_src   = grant & win;
  assign iss_cont  = grant ? win_cont : 3'b000;
  assign iss_tag   = grant ? win_tag : '0;
  assign req_ready = grant ? (win ? 2'b10 : 2'b01) : 2'b00;

  assign res_valid = (count_q != '0);
  assign pop       = res_ready & res_valid;
  assign rb_wr     = pipe_vld_q[PIPE_DEPTH-1] & ~flush;

  assign res_src   = res_valid & rb_src_q[rd_ptr_q];
  assign res_err   = res_valid & rb_err_q[rd_ptr_q];
  assign res_tag   = res_valid ? rb_tag_q[rd_ptr_q] : '0;
  assign rb_wr_ptr = wr_ptr_q;
  assign rb_rd_ptr = rd_ptr_q;
  assign busy      = (|pipe_vld_q) | res_valid;

  // FSM next state
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle, StIssue: begin
        if (can_try && need_gap) begin
          state_d   = StGap;
          gap_cnt_d = GapInit;
        end else if (|req_valid) begin
          if (credits_q != '0) begin
            state_d = StIssue;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q - AgeW'(1);
        if (gap_cnt_q <= AgeW'(1)) begin
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d   = StIdle;
      gap_cnt_d = '0;
    end
  end

  // Cont history, arbitration pointer, credits, buffer occupancy
  always_comb begin
    age_d       = (age_q < AgeSat) ? age_q + AgeW'(1) : age_q;
    last_cont_d = last_cont_q;
    rr_d        = rr_q;
    credits_d   = credits_q;
    count_d     = count_q;

    if (grant) begin
      rr_d = ~win;
      if (win_legal) begin
        last_cont_d = win_cont;
        age_d       = AgeW'(1);
      end
    end

    unique case ({grant, pop})
      2'b10:   credits_d = credits_q - CntW'(1);
      2'b01:   credits_d = credits_q + CntW'(1);
      default: credits_d = credits_q;
    endcase

    unique case ({rb_wr, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      age_d       = AgeSat;
      last_cont_d = 3'b000;
      credits_d   = CreditsFull;
      count_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gap_cnt_q   <= '0;
      age_q       <= AgeSat;
      last_cont_q <= 3'b000;
      rr_q        <= 1'b0;
      credits_q   <= CreditsFull;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      age_q       <= age_d;
      last_cont_q <= last_cont_d;
      rr_q        <= rr_d;
      credits_q   <= credits_d;
      count_q     <= count_d;
    end
  end

  // Tracking shift: one stage per cycle, valid cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      pipe_src_q <= '0;
      pipe_err_q <= '0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
        pipe_tag_q[k] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= grant;
      pipe_src_q[0] <= win;
      pipe_err_q[0] <= ~win_legal;
      pipe_tag_q[0] <= win_tag;
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_src_q[k] <= pipe_src_q[k-1];
        pipe_err_q[k] <= pipe_err_q[k-1];
        pipe_tag_q[k] <= pipe_tag_q[k-1];
      end
      if (flush) begin
        pipe_vld_q <= '0;
      end
    end
  end

  // Result buffer: write from the last pipe stage, pop from the head; both may happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned k = 0; k < RES_DEPTH; k++) begin
        rb_src_q[k] <= 1'b0;
        rb_err_q[k] <= 1'b0;
        rb_tag_q[k] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (rb_wr) begin
        rb_src_q[wr_ptr_q] <= pipe_src_q[PIPE_DEPTH-1];
        rb_err_q[wr_ptr_q] <= pipe_err_q[PIPE_DEPTH-1];
        rb_tag_q[wr_ptr_q] <= pipe_tag_q[PIPE_DEPTH-1];
        wr_ptr_q           <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

endmodule
